// File: rtl/sensor_test_pkg.sv
// Shared mode encodings, LFSR taps and default identity constants for the sensor test generator.
package sensor_test_pkg;

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [7:0]  DEFAULT_ID_BYTE   = 8'h4D;
  localparam int          DEFAULT_SEED_STEP = 50;

  // Galois right shift; an all-zero state would lock up, so it restarts from 1 first.
  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    logic [15:0] seeded;
    seeded = (state == 16'd0) ? 16'd1 : state;
    return seeded[0] ? ((seeded >> 1) ^ LFSR_TAPS) : (seeded >> 1);
  endfunction

endpackage

// File: rtl/sensor_test_chan.sv
// One test-pattern channel: value, triangle direction and the per-mode step.
// MODE=3 is an LFSR only when SENSOR_TEST_GEN_LFSR_EN is defined, otherwise it holds.
module sensor_test_chan
  import sensor_test_pkg::*;
#(
  parameter int              CH_W      = 16,
  parameter int unsigned     TRI_MAX   = 65535,
  parameter logic [CH_W-1:0] RESET_VAL = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            SAMPLE_TICK,
  input  logic [1:0]      MODE,
  output logic [CH_W-1:0] NEXT_VALUE
);

  localparam logic [CH_W:0] TRI_TOP = (CH_W+1)'(TRI_MAX);

  logic [CH_W-1:0] value;
  logic            dir_up;
  logic            in_tri;
  logic            eff_up;
  logic            next_dir_up;

`ifdef SENSOR_TEST_GEN_LFSR_EN
  if (CH_W != 16) begin : g_lfsr_width_check
    $error("sensor_test_chan: LFSR mode requires CH_W == 16");
  end
`endif

  always_comb begin
    NEXT_VALUE  = value;
    next_dir_up = dir_up;
    // A tick that enters triangle mode from another mode always starts climbing.
    eff_up      = in_tri ? dir_up : 1'b1;
    case (MODE)
      MODE_RAMP: NEXT_VALUE = value + CH_W'(1);
      MODE_TRI: begin
        next_dir_up = eff_up;
        if (eff_up) begin
          if (({1'b0, value} + (CH_W+1)'(1)) >= TRI_TOP) begin
            NEXT_VALUE  = TRI_TOP[CH_W-1:0];
            next_dir_up = 1'b0;
          end else begin
            NEXT_VALUE = value + CH_W'(1);
          end
        end else begin
          if (value <= CH_W'(1)) begin
            NEXT_VALUE  = '0;
            next_dir_up = 1'b1;
          end else begin
            NEXT_VALUE = value - CH_W'(1);
          end
        end
      end
      MODE_HOLD: NEXT_VALUE = value;
`ifdef SENSOR_TEST_GEN_LFSR_EN
      MODE_LFSR: NEXT_VALUE = CH_W'(lfsr_step(16'(value)));
`else
      MODE_LFSR: NEXT_VALUE = value;
`endif
      default:   NEXT_VALUE = value;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      value  <= RESET_VAL;
      dir_up <= 1'b1;
      in_tri <= 1'b0;
    end else if (SAMPLE_TICK) begin
      value  <= NEXT_VALUE;
      dir_up <= next_dir_up;
      in_tri <= (MODE == MODE_TRI);
    end
  end

endmodule

// File: rtl/sensor_test_gen.sv
// Multi-channel sensor test-pattern generator with a valid/ack packet register and overrun counter.
// Optional LFSR pattern for MODE=3 is enabled by defining SENSOR_TEST_GEN_LFSR_EN.
module sensor_test_gen
  import sensor_test_pkg::*;
#(
  parameter logic [7:0]  ID_BYTE   = DEFAULT_ID_BYTE,
  parameter int          NUM_CH    = 3,
  parameter int          CH_W      = 16,
  parameter int          TS_W      = 24,
  parameter int          SEED_STEP = DEFAULT_SEED_STEP,
  parameter int unsigned TRI_MAX   = 2**CH_W - 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         SAMPLE_TICK,
  input  logic [1:0]                   MODE,
  input  logic [TS_W-1:0]              TIMESTAMP,
  output logic [NUM_CH*CH_W+TS_W+7:0]  DATA,
  output logic                         DATA_VALID,
  input  logic                         DATA_ACK,
  output logic [7:0]                   OVERRUN_CNT
);

  if (NUM_CH < 1 || NUM_CH > 4 || CH_W < 8 || CH_W > 16) begin : g_param_check
    $error("sensor_test_gen: NUM_CH must be 1..4 and CH_W 8..16");
  end

  logic [NUM_CH*CH_W-1:0]        chan_next;
  logic [NUM_CH*CH_W+TS_W+7:0]   packet;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    sensor_test_chan #(
      .CH_W      (CH_W),
      .TRI_MAX   (TRI_MAX),
      .RESET_VAL (CH_W'(k * SEED_STEP))
    ) u_chan (
      .CLK         (CLK),
      .RESET       (RESET),
      .SAMPLE_TICK (SAMPLE_TICK),
      .MODE        (MODE),
      .NEXT_VALUE  (chan_next[k*CH_W +: CH_W])
    );
  end

  assign packet = {chan_next, TIMESTAMP, ID_BYTE};

  // The packet is built from the post-step channel values so it lands on the tick edge itself.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DATA        <= '0;
      DATA_VALID  <= 1'b0;
      OVERRUN_CNT <= 8'd0;
    end else if (SAMPLE_TICK) begin
      if (!DATA_VALID || DATA_ACK) begin
        DATA       <= packet;
        DATA_VALID <= 1'b1;
      end else if (OVERRUN_CNT != 8'hFF) begin
        OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
      end
    end else if (DATA_VALID && DATA_ACK) begin
      DATA_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_test_gen.sv
// Directed self-checking bench for sensor_test_gen (default build; LFSR expectations follow SENSOR_TEST_GEN_LFSR_EN).
module tb_sensor_test_gen;
  import sensor_test_pkg::*;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        sampleTick = 1'b0;
  logic [1:0]  mode = MODE_RAMP;
  logic [23:0] timestamp = 24'd0;
  logic        dataAck = 1'b0;
  logic [79:0] data;
  logic        dataValid;
  logic [7:0]  overrunCnt;
  logic [79:0] triData;
  logic        triValid;
  logic [7:0]  triOverrun;

  int checkCount = 0;
  int failCount  = 0;

  logic [1:0]  triMode [19] = '{MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI,
                                MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI,
                                MODE_TRI, MODE_TRI, MODE_TRI, MODE_TRI, MODE_RAMP, MODE_TRI,
                                MODE_TRI};
  logic [15:0] triExp  [19] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd4, 16'd3, 16'd2,
                                16'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd4,
                                16'd5, 16'd5, 16'd4};

  sensor_test_gen dut (
    .CLK         (clock),
    .RESET       (resetN),
    .SAMPLE_TICK (sampleTick),
    .MODE        (mode),
    .TIMESTAMP   (timestamp),
    .DATA        (data),
    .DATA_VALID  (dataValid),
    .DATA_ACK    (dataAck),
    .OVERRUN_CNT (overrunCnt)
  );

  sensor_test_gen #(.TRI_MAX(5)) dutTri (
    .CLK         (clock),
    .RESET       (resetN),
    .SAMPLE_TICK (sampleTick),
    .MODE        (mode),
    .TIMESTAMP   (timestamp),
    .DATA        (triData),
    .DATA_VALID  (triValid),
    .DATA_ACK    (dataAck),
    .OVERRUN_CNT (triOverrun)
  );

  always #5 clock = ~clock;

  function automatic logic [79:0] pkt(input logic [15:0] c2, input logic [15:0] c1,
                                      input logic [15:0] c0, input logic [23:0] ts);
    return {c2, c1, c0, ts, 8'h4D};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle of stimulus, driven at the falling edge; returns just after the rising edge.
  task automatic applyStimulus(input logic tick, input logic ack, input logic [1:0] m, input logic [23:0] ts);
    @(negedge clock);
    sampleTick = tick;
    dataAck    = ack;
    mode       = m;
    timestamp  = ts;
    @(posedge clock);
    #1;
  endtask

  task automatic resetPulse();
    @(negedge clock);
    sampleTick = 1'b0;
    dataAck    = 1'b0;
    #2 resetN = 1'b0;
    #1;
    checkOutput("rst_valid", dataValid, 1'b0);
    checkOutput("rst_data", data, 80'd0);
    checkOutput("rst_ovr", overrunCnt, 8'd0);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    #12;
    checkOutput("por_data", data, 80'd0);
    checkOutput("por_valid", dataValid, 1'b0);
    checkOutput("por_ovr", overrunCnt, 8'd0);
    checkOutput("por_tri_valid", triValid, 1'b0);
    @(negedge clock);
    resetN = 1'b1;

    applyStimulus(1'b1, 1'b0, MODE_RAMP, 24'h123456);
    checkOutput("first_valid", dataValid, 1'b1);
    checkOutput("first_id", data[7:0], 8'h4D);
    checkOutput("first_ts", data[31:8], 24'h123456);
    checkOutput("first_ch0", data[47:32], 16'd1);
    checkOutput("first_pkt", data, pkt(16'd101, 16'd51, 16'd1, 24'h123456));

    applyStimulus(1'b0, 1'b1, MODE_RAMP, 24'h0);
    checkOutput("ack_clear", dataValid, 1'b0);

    applyStimulus(1'b1, 1'b0, MODE_RAMP, 24'h000A01);
    checkOutput("ovr_first_pkt", data, pkt(16'd102, 16'd52, 16'd2, 24'h000A01));
    applyStimulus(1'b1, 1'b0, MODE_RAMP, 24'h000A02);
    checkOutput("ovr_cnt1", overrunCnt, 8'd1);
    applyStimulus(1'b1, 1'b0, MODE_RAMP, 24'h000A03);
    checkOutput("ovr_cnt2", overrunCnt, 8'd2);
    checkOutput("ovr_hold_pkt", data, pkt(16'd102, 16'd52, 16'd2, 24'h000A01));
    checkOutput("ovr_valid", dataValid, 1'b1);
    applyStimulus(1'b0, 1'b1, MODE_RAMP, 24'h0);
    checkOutput("ovr_ack_clear", dataValid, 1'b0);
    applyStimulus(1'b0, 1'b1, MODE_RAMP, 24'h0);
    checkOutput("idle_ack_valid", dataValid, 1'b0);
    checkOutput("idle_ack_data", data, pkt(16'd102, 16'd52, 16'd2, 24'h000A01));
    checkOutput("idle_ack_ovr", overrunCnt, 8'd2);

    applyStimulus(1'b1, 1'b0, MODE_RAMP, 24'h000B01);
    checkOutput("adv_pkt", data, pkt(16'd105, 16'd55, 16'd5, 24'h000B01));
    applyStimulus(1'b1, 1'b1, MODE_RAMP, 24'h000B02);
    checkOutput("tickack_valid", dataValid, 1'b1);
    checkOutput("tickack_pkt", data, pkt(16'd106, 16'd56, 16'd6, 24'h000B02));
    checkOutput("tickack_ovr", overrunCnt, 8'd2);

    applyStimulus(1'b1, 1'b1, MODE_HOLD, 24'h000C01);
    checkOutput("hold_pkt", data, pkt(16'd106, 16'd56, 16'd6, 24'h000C01));
    applyStimulus(1'b0, 1'b1, MODE_RAMP, 24'h0);
    applyStimulus(1'b0, 1'b0, MODE_RAMP, 24'h0);
    applyStimulus(1'b1, 1'b0, MODE_RAMP, 24'h000C02);
    checkOutput("notick_pkt", data, pkt(16'd107, 16'd57, 16'd7, 24'h000C02));

    resetPulse();
    applyStimulus(1'b0, 1'b0, MODE_RAMP, 24'h0);
    checkOutput("post_rst_valid", dataValid, 1'b0);

    applyStimulus(1'b1, 1'b0, MODE_LFSR, 24'h000D01);
`ifdef SENSOR_TEST_GEN_LFSR_EN
    checkOutput("lfsr_pkt", data, pkt(16'd50, 16'd25, 16'hB400, 24'h000D01));
`else
    checkOutput("mode3_hold_pkt", data, pkt(16'd100, 16'd50, 16'd0, 24'h000D01));
`endif

    resetPulse();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, 1'b1, triMode[i], 24'(i));
      checkOutput($sformatf("tri_ch0_%0d", i), triData[47:32], triExp[i]);
    end
    checkOutput("tri_ovr", triOverrun, 8'd0);

    resetPulse();
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 1'b1, MODE_RAMP, 24'(i));
    end
    checkOutput("wrap_pre_ch0", data[47:32], 16'hFFFF);
    applyStimulus(1'b1, 1'b1, MODE_RAMP, 24'h000E01);
    checkOutput("wrap_pkt", data, pkt(16'd100, 16'd50, 16'd0, 24'h000E01));
    checkOutput("wrap_ovr", overrunCnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sensor_test_gen.md
SENSOR_TEST_GEN -- requirements
Module: sensor_test_gen

Interface
REQ-001 SHALL have parameter ID_BYTE, default 8'h4D, packet identifier byte.
REQ-002 SHALL have parameter NUM_CH, default 3, channel count (legal range 1..4).
REQ-003 SHALL have parameter CH_W, default 16, channel sample width (legal range 8..16).
REQ-004 SHALL have parameter TS_W, default 24, timestamp width.
REQ-005 SHALL have parameter SEED_STEP, default 50, reset-value spacing between channels.
REQ-006 SHALL have parameter TRI_MAX, default 2**CH_W-1, triangle-mode upper bound.
REQ-007 SHALL have ports: CLK  input  1  single clock; RESET  input  1  asynchronous active-low reset.
REQ-008 SHALL have port SAMPLE_TICK  input  1  one-cycle sample strobe.
REQ-009 SHALL have port MODE  input  2  0=ramp, 1=triangle, 2=hold, 3=LFSR.
REQ-010 SHALL have port TIMESTAMP  input  TS_W  time tag captured per packet.
REQ-011 SHALL have port DATA  output  NUM_CH*CH_W+TS_W+8  packet {ch[NUM_CH-1]..ch[0],TIMESTAMP,ID_BYTE}.
REQ-012 SHALL have ports: DATA_VALID  output  1  packet pending; DATA_ACK  input  1  consumer accept.
REQ-013 SHALL have port OVERRUN_CNT  output  8  saturating count of dropped packets.

Function
REQ-014 On SAMPLE_TICK every channel SHALL advance per MODE sampled in that same cycle; no advance otherwise.
REQ-015 Ramp: ch <= ch+1, modulo 2**CH_W, wrapping to 0 silently.
REQ-016 Triangle: direction up: if ch+1 >= TRI_MAX then ch <= TRI_MAX, dir <= down, else ch+1; down: if ch <= 1 then ch <= 0, dir <= up, else ch-1.
REQ-017 Entering triangle from another mode SHALL set dir=up on that tick.
REQ-018 Hold: ch unchanged.
REQ-019 LFSR: Galois shift right, taps 16'hB400; a zero state SHALL be forced to 16'h0001 before shifting.
REQ-020 Packet SHALL be registered the cycle after SAMPLE_TICK using post-advance channel values and TIMESTAMP sampled on the tick; DATA_VALID rises in that same cycle.
REQ-021 DATA and DATA_VALID SHALL hold stable until DATA_ACK=1 while DATA_VALID=1; DATA_VALID clears the next cycle.
REQ-022 Tick while DATA_VALID=1 and DATA_ACK=0: channels still advance, DATA not overwritten, OVERRUN_CNT increments (saturates at 255).
REQ-023 Tick coincident with DATA_ACK on a valid packet: new packet loads, DATA_VALID stays 1, no overrun.
REQ-024 DATA_ACK with DATA_VALID=0 SHALL be ignored.

Reset
REQ-025 RESET low SHALL asynchronously set ch[k]=k*SEED_STEP (mod 2**CH_W), all dir=up, DATA=0, DATA_VALID=0, OVERRUN_CNT=0.
REQ-026 Reset mid-handshake SHALL discard the pending packet; no ack required.

Configuration
REQ-027 Macro SENSOR_TEST_GEN_LFSR_EN defined: MODE=3 is LFSR per REQ-019; CH_W other than 16 SHALL fail elaboration.
REQ-028 Macro undefined: no LFSR logic; MODE=3 SHALL behave as hold.

Structure
REQ-029 Package sensor_test_pkg SHALL hold mode encodings, LFSR tap constant, default ID_BYTE and SEED_STEP.
REQ-030 Per-channel generator SHALL be sub-module sensor_test_chan (value, direction, mode step), instantiated NUM_CH times.

Verification
REQ-031 Defaults, reset release, ramp, one tick -> DATA_VALID after 1 cycle, ch0=1, ch1=51, ch2=101, low byte 8'h4D, TIMESTAMP captured.
REQ-032 Ramp, ch0 preloaded via 65535 ticks with acks -> next tick ch0=0 (wrap), no overrun.
REQ-033 Triangle, TRI_MAX=5 -> ch0 sequence 1,2,3,4,5,4,3,2,1,0,1.
REQ-034 Three ticks without DATA_ACK -> DATA holds first packet, OVERRUN_CNT=2; ack -> DATA_VALID=0 next cycle.
REQ-035 Tick and DATA_ACK same cycle -> DATA_VALID stays 1, new packet, OVERRUN_CNT unchanged.
REQ-036 LFSR_EN, MODE=3, ch0 reset 0 -> first tick ch0=16'hB400; without macro ch0 stays 0.
